// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-port RAM access arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the port that was not granted last wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_id,
  output logic       grant_valid
);

  // Pick the winner combinationally from the current requests and the last grant.
  always_comb begin
    grant_valid = |req;
    grant_id    = PORT0;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[1]) begin
      grant_id = PORT1;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares one async-read / sync-write single-port RAM between two requesters.
// Each transaction takes three cycles: IDLE (grant), ACCESS (RAM cycle), RESP (ack).
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  state_e state_q, state_d;

  logic              grant_id;
  logic              grant_valid;
  logic              grant_take;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              sel_q;
  logic              we_q;
  logic              last_grant_q;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .grant_id   (grant_id),
    .grant_valid(grant_valid)
  );

  // Winner's request fields, muxed for latching at the grant edge.
  always_comb begin
    win_we    = (grant_id == PORT1) ? we1    : we0;
    win_addr  = (grant_id == PORT1) ? addr1  : addr0;
    win_wdata = (grant_id == PORT1) ? wdata1 : wdata0;
  end

  // Next-state logic: arbitration happens only in IDLE, no preemption afterwards.
  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch and fairness pointer; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= PORT0;
      we_q         <= 1'b0;
      last_grant_q <= PORT1;
    end else begin
      if (grant_take) begin
        sel_q <= grant_id;
        we_q  <= win_we;
      end
      if (state_q == ST_RESP) begin
        last_grant_q <= sel_q;
      end
    end
  end

  // RAM drive registers: loaded at the grant edge so they are valid throughout ACCESS.
  // The address and data registers double as the latched request address/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      ram_we_q <= 1'b0;
      if (grant_take) begin
        ram_we_q   <= win_we;
        ram_addr_q <= win_addr;
        ram_din_q  <= win_wdata;
      end
    end
  end

  // Ack pulses are set on leaving ACCESS so they are high exactly during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      ack0_q <= (state_q == ST_ACCESS) && (sel_q == PORT0);
      ack1_q <= (state_q == ST_ACCESS) && (sel_q == PORT1);
    end
  end

  // Read data capture at the end of a read ACCESS; held until that port's next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if ((state_q == ST_ACCESS) && !we_q) begin
      if (sel_q == PORT1) begin
        rdata1_q <= ram_dout;
      end else begin
        rdata0_q <= ram_dout;
      end
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter with a behavioural RAM and reference model.
module tb_ram_access_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          busy;
  logic          mem_clr;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: memory contents, last read value per port, last granted port.
  logic [DW-1:0] model_mem [1<<AW];
  logic [DW-1:0] model_rd  [2];
  int            model_last;

  logic [DW-1:0] mem [1<<AW];

  always #5 clk = ~clk;

  // Behavioural RAM: async read, sync write.
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
  end

  ram_access_arbiter #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .we0     (we0),
    .addr0   (addr0),
    .wdata0  (wdata0),
    .ack0    (ack0),
    .rdata0  (rdata0),
    .req1    (req1),
    .we1     (we1),
    .addr1   (addr1),
    .wdata1  (wdata1),
    .ack1    (ack1),
    .rdata1  (rdata1),
    .ram_we  (ram_we),
    .ram_addr(ram_addr),
    .ram_din (ram_din),
    .ram_dout(ram_dout),
    .busy    (busy)
  );

  task automatic drive(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == 1) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 1) ? ack1 : ack0;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p == 1) ? rdata1 : rdata0;
  endfunction

  task automatic model_reset();
    model_rd[0] = '0;
    model_rd[1] = '0;
    model_last  = 1;
  endtask

  // Runs one lone transaction on port p (inputs change and outputs sampled on negedges).
  task automatic run_single(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int ack_k, output int we_cnt,
                            output int other_acks, output logic [DW-1:0] rd);
    ack_k = -1; we_cnt = 0; other_acks = 0; rd = '0;
    drive(p, 1'b1, w, a, d);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (ack_of(1 - p)) other_acks++;
      if (ack_of(p)) begin
        ack_k = k;
        rd    = rdata_of(p);
        break;
      end
    end
    drive(p, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    if (ram_we) we_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = '0;
    vectors++;
    if ({ack0, ack1, busy, ram_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ack0/ack1/busy/ram_we=%b required 0000",
               {ack0, ack1, busy, ram_we});
    end
    vectors++;
    if ({rdata0, rdata1, ram_addr, ram_din} !== '0) begin
      errors++;
      $display("FAIL reset_data: rdata0=%h rdata1=%h ram_addr=%h ram_din=%h required 0",
               rdata0, rdata1, ram_addr, ram_din);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int ack_k, we_cnt, oth;
    logic [DW-1:0] rd;
    run_single(0, 1'b1, 3'd3, 8'hA5, ack_k, we_cnt, oth, rd);
    model_mem[3] = 8'hA5; model_last = 0;
    vectors++;
    if (ack_k !== 2 || we_cnt !== 1 || oth !== 0) begin
      errors++;
      $display("FAIL wr_a5: ack_k=%0d we_cycles=%0d ack1s=%0d required 2 1 0", ack_k, we_cnt, oth);
    end
    vectors++;
    if (mem[3] !== 8'hA5) begin
      errors++;
      $display("FAIL wr_a5_mem: mem[3]=%h required a5", mem[3]);
    end
    run_single(0, 1'b0, 3'd3, 8'h00, ack_k, we_cnt, oth, rd);
    model_rd[0] = model_mem[3];
    vectors++;
    if (ack_k !== 2 || we_cnt !== 0 || oth !== 0 || rd !== 8'hA5) begin
      errors++;
      $display("FAIL rd_a5: ack_k=%0d we_cycles=%0d ack1s=%0d rdata0=%h required 2 0 0 a5",
               ack_k, we_cnt, oth, rd);
    end
  endtask

  task automatic test_random_single();
    int ack_k, we_cnt, oth, p;
    logic w;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd, exp_rd;
    for (int i = 0; i < 24; i++) begin
      p = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, (1 << AW) - 1));
      d = DW'($urandom);
      exp_rd = w ? model_rd[p] : model_mem[a];
      run_single(p, w, a, d, ack_k, we_cnt, oth, rd);
      if (w) model_mem[a] = d;
      else model_rd[p] = model_mem[a];
      model_last = p;
      vectors++;
      if (ack_k !== 2 || we_cnt !== int'(w) || oth !== 0 || rd !== exp_rd) begin
        errors++;
        $display("FAIL rand_%0d p%0d we=%0b a=%0d: ack_k=%0d we_cyc=%0d oth=%0d rd=%h req 2 %0d 0 %h",
                 i, p, w, a, ack_k, we_cnt, oth, rd, int'(w), exp_rd);
      end
    end
  endtask

  // Two simultaneous writes; expected order comes from the last-served port.
  task automatic run_dual_writes(input string tag, input logic [AW-1:0] a0,
                                 input logic [DW-1:0] d0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d1);
    int order[$];
    int times[$];
    int we_cnt = 0;
    int dual = 0;
    int first;
    first = 1 - model_last;
    drive(0, 1'b1, 1'b1, a0, d0);
    drive(1, 1'b1, 1'b1, a1, d1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (ack0 && ack1) dual++;
      if (ack0) begin order.push_back(0); times.push_back(k); drive(0, 1'b0, 1'b0, '0, '0); end
      if (ack1) begin order.push_back(1); times.push_back(k); drive(1, 1'b0, 1'b0, '0, '0); end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_mem[a0] = d0;
    model_mem[a1] = d1;
    model_last = 1 - first;
    vectors++;
    if (order.size() !== 2 || dual !== 0 || we_cnt !== 2) begin
      errors++;
      $display("FAIL %s_count: acks=%0d dual=%0d we_cycles=%0d required 2 0 2",
               tag, order.size(), dual, we_cnt);
    end else begin
      vectors++;
      if (order[0] !== first || order[1] !== 1 - first || times[0] !== 2 || times[1] !== 5) begin
        errors++;
        $display("FAIL %s_order: ports %0d,%0d at %0d,%0d required %0d,%0d at 2,5",
                 tag, order[0], order[1], times[0], times[1], first, 1 - first);
      end
    end
    vectors++;
    if (mem[a0] !== d0 || mem[a1] !== d1) begin
      errors++;
      $display("FAIL %s_mem: mem[%0d]=%h mem[%0d]=%h required %h %h",
               tag, a0, mem[a0], a1, mem[a1], d0, d1);
    end
  endtask

  task automatic test_tie_from_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_dual_writes("tie_reset", 3'd1, 8'h11, 3'd2, 8'h22);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int p, first;
    logic [AW-1:0] a [2];
    a[0] = AW'($urandom_range(0, (1 << AW) - 1));
    a[1] = AW'($urandom_range(0, (1 << AW) - 1));
    first = 1 - model_last;
    drive(0, 1'b1, 1'b0, a[0], '0);
    drive(1, 1'b1, 1'b0, a[1], '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        vectors++;
        if ((ack0 && ack1) || p !== (first ^ (n & 1)) || k !== 2 + 3 * n ||
            rdata_of(p) !== model_mem[a[p]]) begin
          errors++;
          $display("FAIL b2b_%0d: ack0=%0b ack1=%0b k=%0d rdata=%h required port %0d k=%0d rdata=%h",
                   n, ack0, ack1, k, rdata_of(p), first ^ (n & 1), 2 + 3 * n, model_mem[a[p]]);
        end
        model_rd[p] = model_mem[a[p]];
        model_last  = p;
        n++;
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    vectors++;
    if (n !== 4) begin
      errors++;
      $display("FAIL b2b_acks: %0d acks required 4", n);
    end
  endtask

  task automatic test_late_request();
    int ack_k, we_cnt, oth;
    int k0 = -1;
    int k1 = -1;
    logic [DW-1:0] rd, r0, r1;
    run_single(1, 1'b1, 3'd4, 8'h5A, ack_k, we_cnt, oth, rd);
    run_single(1, 1'b1, 3'd6, 8'hC3, ack_k, we_cnt, oth, rd);
    model_mem[4] = 8'h5A; model_mem[6] = 8'hC3; model_last = 1;
    r0 = '0; r1 = '0;
    drive(0, 1'b1, 1'b0, 3'd4, '0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        drive(1, 1'b1, 1'b0, 3'd6, '0);
        addr0 = 3'd6;
      end
      if (ack0 && k0 < 0) begin k0 = k; r0 = rdata0; drive(0, 1'b0, 1'b0, '0, '0); end
      if (ack1 && k1 < 0) begin k1 = k; r1 = rdata1; drive(1, 1'b0, 1'b0, '0, '0); end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_rd[0] = 8'h5A; model_rd[1] = 8'hC3; model_last = 1;
    vectors++;
    if (k0 !== 2 || r0 !== 8'h5A) begin
      errors++;
      $display("FAIL late_p0: ack0 at %0d rdata0=%h required 2 5a", k0, r0);
    end
    vectors++;
    if (k1 !== 5 || r1 !== 8'hC3) begin
      errors++;
      $display("FAIL late_p1: ack1 at %0d rdata1=%h required 5 c3", k1, r1);
    end
  endtask

  task automatic test_reset_abort();
    logic saw_ack;
    drive(1, 1'b1, 1'b0, 3'd2, '0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    model_reset();
    saw_ack = ack0 | ack1;
    vectors++;
    if ({ack1, busy, ram_we} !== 3'b000 || rdata1 !== '0) begin
      errors++;
      $display("FAIL abort_state: ack1/busy/ram_we=%b rdata1=%h required 000 00",
               {ack1, busy, ram_we}, rdata1);
    end
    repeat (3) begin
      @(negedge clk);
      saw_ack = saw_ack | ack0 | ack1;
    end
    vectors++;
    if (saw_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_ack: ack seen=%b required 0", saw_ack);
    end
    run_dual_writes("post_abort", 3'd5, 8'h77, 3'd6, 8'h88);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_random_single();
    test_tie_from_reset();
    test_back_to_back();
    test_late_request();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
